fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the byte-addressable instruction memory and consumes its combinational read data. It holds the PC, issues one word read per cycle while it has buffer space, and queues {pc, insn} pairs in a small FIFO. Decode drains the FIFO through a valid/ready handshake. Redirects flush the FIFO and restart fetch; a misaligned redirect puts the block into a sticky fault state.

Parameters:
AWIDTH, 32, address/PC width
DWIDTH, 32, instruction word width
BASE_ADDR, 32'h01000000, reset PC; equals the memory base address
FIFO_DEPTH, 2, number of fetch-buffer entries (power of two, at least 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
imem_addr_o  out  AWIDTH  read address to instruction memory; always equals current PC
imem_read_en_o  out  1  high in the cycle a fetch is committed (fetch_fire)
imem_data_i  in  DWIDTH  combinational read data for imem_addr_o, little-endian word
redirect_valid_i  in  1  one-cycle request to restart fetch at redirect_pc_i
redirect_pc_i  in  AWIDTH  new PC
out_valid_o  out  1  FIFO head is valid
out_ready_i  in  1  decode accepts the head this cycle
out_pc_o  out  AWIDTH  PC of the head entry; 0 when empty
out_insn_o  out  DWIDTH  instruction of the head entry; 0 when empty
fault_o  out  1  sticky misaligned-redirect fault

Behaviour:
- Reset (rst=0, asynchronous): PC=BASE_ADDR, FIFO count=0, read/write pointers=0, state=RUN, fault_o=0. Therefore out_valid_o=0, imem_read_en_o=0 while reset is held, out_pc_o=0, out_insn_o=0.
- States:
  - RUN: normal fetch.
  - FAULT: entered from RUN on a misaligned redirect (redirect_pc_i[1:0] != 0).
  - FAULT is left only by reset. In FAULT: fault_o=1, no fetches, FIFO held empty, out_valid_o=0.
- Signals (combinational):
  - pop = out_valid_o & out_ready_i.
  - fetch_fire = (state==RUN) & ~redirect_valid_i & (count < FIFO_DEPTH | pop).
  - imem_read_en_o = fetch_fire.
- On fetch_fire, at the clock edge:
  - push {PC, imem_data_i} at the write pointer;
  - PC <= PC + 4, modulo 2^AWIDTH (0xFFFFFFFC wraps to 0x00000000).
- Latency: the memory is combinational, so the word fetched in cycle N is presented at the FIFO head in cycle N+1. After reset deasserts, out_valid_o rises one edge later with out_pc_o=BASE_ADDR.
- FIFO:
  - circular, pointers wrap modulo FIFO_DEPTH;
  - count += push − pop;
  - simultaneous push and pop when full is legal, and count stays FIFO_DEPTH;
  - pop when empty is impossible because out_valid_o=0.
- out_valid_o = (count != 0). Head outputs are stable while out_valid_o=1 and out_ready_i=0 (no drop, no reorder).
- Redirect (redirect_valid_i=1 in RUN) has priority over push and pop in the same cycle:
  - FIFO flushed (count=0, pointers=0);
  - no push that cycle; any pop that cycle is discarded;
  - aligned target: PC <= redirect_pc_i, and fetch resumes the next cycle;
  - misaligned target: state <= FAULT, fault_o=1 from the next cycle, PC unchanged.
- Redirect in FAULT is ignored.
- The PC is not range-checked; out-of-range reads return whatever the memory drives (X passes through).

Test Plan:
1. Reset release, BASE_ADDR=0x01000000, memory words 0x00500093, 0x00A00113, out_ready_i=1 → head pc 0x01000000 / insn 0x00500093 on cycle 1, then 0x01000004 / 0x00A00113 on cycle 2; imem_read_en_o=1 every cycle.
2. out_ready_i=0 for 5 cycles → exactly 2 fetches, then imem_read_en_o=0, PC=0x01000008, head held at 0x01000000. Raise out_ready_i → entries drain in order; fetch resumes in the same cycle as the first pop.
3. Full FIFO with simultaneous pop → push and pop occur in the same cycle, count stays 2, and the pc sequence has no gap.
4. redirect_valid_i=1 with redirect_pc_i=0x01000040 while FIFO is full and out_ready_i=1 → next cycle out_valid_o=0, imem_addr_o=0x01000040; following cycle head pc=0x01000040.
5. redirect_pc_i=0x01000042 → fault_o=1, out_valid_o=0, imem_read_en_o=0 indefinitely; a later aligned redirect is ignored; asserting rst (low) mid-operation immediately clears fault_o and restores PC=0x01000000.
6. Redirect to 0xFFFFFFFC, out_ready_i=1 → heads with pc 0xFFFFFFFC, then 0x00000000 (wrap).

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads one word per cycle from a combinational
// instruction memory and buffers {pc, insn} pairs in a small FIFO drained by decode.
module fetch_unit #(
    parameter int                AWIDTH     = 32,
    parameter int                DWIDTH     = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR  = 32'h0100_0000,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [AWIDTH-1:0] imem_addr_o,
    output logic              imem_read_en_o,
    input  logic [DWIDTH-1:0] imem_data_i,
    input  logic              redirect_valid_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [AWIDTH-1:0] out_pc_o,
    output logic [DWIDTH-1:0] out_insn_o,
    output logic              fault_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        RUN,
        FAULT
    } state_t;

    state_t state, state_next;

    logic [AWIDTH-1:0] pc;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [AWIDTH-1:0] pc_mem   [FIFO_DEPTH];
    logic [DWIDTH-1:0] insn_mem [FIFO_DEPTH];

    logic running, redirect, aligned, pop, fetch_fire;

    assign running    = (state == RUN);
    assign redirect   = running & redirect_valid_i;
    assign aligned    = (redirect_pc_i[1:0] == 2'b00);
    assign pop        = out_valid_o & out_ready_i;
    assign fetch_fire = running & ~redirect_valid_i & ((count < DEPTH_C) | pop);

    // Reset gates the strobe so memory never sees a read while the block is held.
    assign imem_read_en_o = fetch_fire & rst;
    assign imem_addr_o    = pc;
    assign fault_o        = (state == FAULT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_next;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
        state_next = state;
        if (redirect && !aligned) state_next = FAULT;
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= BASE_ADDR;
        end else if (redirect) begin
            if (aligned) pc <= redirect_pc_i;
        end else if (fetch_fire) begin
            pc <= pc + AWIDTH'(4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (redirect) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fetch_fire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)        rd_ptr <= rd_ptr + PTR_W'(1);
            case ({fetch_fire, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: buffer storage is not reset; out_valid_o masks stale entries, so reset is unneeded.
    always_ff @(posedge clk) begin
        if (fetch_fire) begin
            pc_mem[wr_ptr]   <= pc;
            insn_mem[wr_ptr] <= imem_data_i;
        end
    end

    assign out_valid_o = (count != '0);
    assign out_pc_o    = out_valid_o ? pc_mem[rd_ptr]   : '0;
    assign out_insn_o  = out_valid_o ? insn_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue-based model of the fetch buffer is compared
// against the DUT every cycle, with literal expectations pinning the key scenarios.
module tb_fetch_unit;

    localparam logic [31:0] BASE  = 32'h0100_0000;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_read_en;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_insn;
    logic        fault;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } entry_t;

    entry_t      q[$];
    logic [31:0] m_pc;
    bit          m_fault;
    logic [31:0] saved_pc;

    fetch_unit #(
        .AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr_o     (imem_addr),
        .imem_read_en_o  (imem_read_en),
        .imem_data_i     (imem_data),
        .redirect_valid_i(redirect_valid),
        .redirect_pc_i   (redirect_pc),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_pc_o        (out_pc),
        .out_insn_o      (out_insn),
        .fault_o         (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] insn_at(input logic [31:0] a);
        case (a)
            32'h0100_0000: return 32'h0050_0093;
            32'h0100_0004: return 32'h00A0_0113;
            default:       return a ^ 32'h5A5A_0013;
        endcase
    endfunction

    always_comb imem_data = insn_at(imem_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_fire();
        return rst && !m_fault && !redirect_valid &&
               (q.size() < DEPTH || (q.size() != 0 && out_ready));
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc    = BASE;
        m_fault = 1'b0;
    endtask

    task automatic model_step();
        bit do_pop, do_fire;
        if (!rst || m_fault) return;
        if (redirect_valid) begin
            q.delete();
            if (redirect_pc[1:0] != 2'b00) m_fault = 1'b1;
            else                           m_pc    = redirect_pc;
            return;
        end
        do_pop  = (q.size() != 0) && out_ready;
        do_fire = (q.size() < DEPTH) || do_pop;
        if (do_pop) void'(q.pop_front());
        if (do_fire) begin
            q.push_back('{pc: m_pc, insn: insn_at(m_pc)});
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        check("valid",   out_valid,    q.size() != 0);
        check("head_pc", out_pc,       (q.size() != 0) ? q[0].pc   : 32'h0);
        check("head_in", out_insn,     (q.size() != 0) ? q[0].insn : 32'h0);
        check("read_en", imem_read_en, exp_fire());
        check("addr",    imem_addr,    m_pc);
        check("fault",   fault,        m_fault);
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] pat;
        rst            = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        model_reset();
        repeat (2) tick();
        check("rst_read_en", imem_read_en, 1'b0);
        check("rst_valid",   out_valid,    1'b0);
        check("rst_pc",      out_pc,       32'h0);
        check("rst_addr",    imem_addr,    BASE);

        // Plan 1: first words appear one edge after each fetch
        rst = 1'b1;
        tick();
        check("p1_pc0",   out_pc,       32'h0100_0000);
        check("p1_in0",   out_insn,     32'h0050_0093);
        check("p1_en0",   imem_read_en, 1'b1);
        tick();
        check("p1_pc1",   out_pc,       32'h0100_0004);
        check("p1_in1",   out_insn,     32'h00A0_0113);
        check("p1_en1",   imem_read_en, 1'b1);

        // Plan 2/3: stall from a fresh reset, then drain with simultaneous push/pop
        rst = 1'b0;
        model_reset();
        tick();
        rst       = 1'b1;
        out_ready = 1'b0;
        repeat (5) tick();
        check("p2_addr",  imem_addr,    32'h0100_0008);
        check("p2_head",  out_pc,       32'h0100_0000);
        check("p2_en",    imem_read_en, 1'b0);
        out_ready = 1'b1;
        #1;
        check("p2_resume", imem_read_en, 1'b1);
        tick();
        check("p3_head1", out_pc,       32'h0100_0004);
        tick();
        check("p3_head2", out_pc,       32'h0100_0008);
        check("p3_en",    imem_read_en, 1'b1);

        pat = 16'hB2E4;
        for (int i = 0; i < 16; i++) begin
            out_ready = pat[i];
            tick();
        end

        // Plan 4: redirect while full and popping
        out_ready = 1'b0;
        repeat (2) tick();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0040;
        tick();
        redirect_valid = 1'b0;
        check("p4_valid", out_valid, 1'b0);
        check("p4_addr",  imem_addr, 32'h0100_0040);
        tick();
        check("p4_head",  out_pc,    32'h0100_0040);

        // Plan 6: PC wraps modulo 2^32
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("p6_pc_top", out_pc,   32'hFFFF_FFFC);
        check("p6_in_top", out_insn, 32'hA5A5_FFEF);
        tick();
        check("p6_pc_wrap", out_pc,   32'h0000_0000);
        check("p6_in_wrap", out_insn, 32'h5A5A_0013);

        // Plan 5: misaligned redirect, sticky fault, async reset recovery
        saved_pc       = m_pc;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0042;
        tick();
        redirect_valid = 1'b0;
        check("p5_fault", fault,        1'b1);
        check("p5_valid", out_valid,    1'b0);
        check("p5_en",    imem_read_en, 1'b0);
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0080;
        tick();
        redirect_valid = 1'b0;
        check("p5_sticky", fault,     1'b1);
        check("p5_pc",     imem_addr, saved_pc);
        tick();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("p5_rst_fault", fault,     1'b0);
        check("p5_rst_addr",  imem_addr, BASE);
        check("p5_rst_en",    imem_read_en, 1'b0);
        tick();
        rst = 1'b1;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
